servo_pwm_gen: RTL and testbench

// Servo frame/pulse generator feeding the servo output stage. Accepts 8-bit position commands

---
 rtl/servo_pwm_gen.sv | 173 +++++++++++++++++
 tb/tb_servo_pwm_gen.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen
// Servo frame/pulse generator for the servo output stage. Position commands
// (0..255) arrive over a valid/ready handshake, and at most one command can be
// pending at a time. The block produces a fixed-period frame. Each frame starts
// with a high pulse. The pulse width follows the active position, and the
// active position can be rate-limited so it moves only a set amount per frame.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high
//   enable       1 = generate frames, 0 = idle with output low
//   cmd_valid    position command valid
//   cmd_pos      commanded position 0..255
//   cmd_ready    high when no command is pending; accept on cmd_valid & cmd_ready
//   pwm_out      servo pulse, high for the pulse width at the start of each frame
//   frame_start  high only for the first cycle of every frame
//   at_target    active position equals target position
module servo_pwm_gen #(
    parameter int FRAME_CYCLES = 1000000,
    parameter int MIN_PULSE    = 50000,
    parameter int MAX_PULSE    = 100000,
    parameter int STEP_CYCLES  = 196,
    parameter int SLEW_MAX     = 0,
    parameter int CENTER       = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_pos,
    output logic       cmd_ready,
    output logic       pwm_out,
    output logic       frame_start,
    output logic       at_target
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_CYCLES - 1);
    localparam logic [7:0]    CENTER_POS = 8'(CENTER);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] counter_q, counter_d;
    logic [CW-1:0] width_q, width_d;
    logic [7:0]    pending_q, pending_d;
    logic          pending_valid_q, pending_valid_d;
    logic [7:0]    target_q, target_d;
    logic [7:0]    active_q, active_d;
    logic          pwm_out_q, pwm_out_d;
    logic          frame_start_q, frame_start_d;

    logic          apply;
    logic [7:0]    new_target;
    logic [7:0]    next_active;
    logic [7:0]    diff;

    // The 64-bit intermediate keeps MIN_PULSE + pos*STEP_CYCLES exact for
    // any parameter set. Clamping happens before narrowing to the counter width.
    function automatic logic [CW-1:0] pulse_width(input logic [7:0] pos);
        logic [63:0] full;
        full = 64'(MIN_PULSE) + 64'(pos) * 64'(STEP_CYCLES);
        if (full > 64'(MAX_PULSE)) begin
            full = 64'(MAX_PULSE);
        end
        return full[CW-1:0];
    endfunction

    // Next-state logic. The pwm_out and frame_start outputs are computed from
    // the next counter and width, so the registered outputs line up with the
    // counter. Counter value 0 is therefore the frame_start cycle and the
    // first pulse cycle.
    always_comb begin
        state_d         = state_q;
        counter_d       = counter_q;
        width_d         = width_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        target_d        = target_q;
        active_d        = active_q;
        pwm_out_d       = 1'b0;
        frame_start_d   = 1'b0;

        // A new position takes effect at the start of a frame: either on the
        // IDLE->RUN edge or on the last cycle of a running frame.
        apply = ((state_q == IDLE) && enable) ||
                ((state_q == RUN) && enable && (counter_q == LAST_COUNT));

        new_target = pending_valid_q ? pending_q : target_q;
        diff       = (active_q > new_target) ? (active_q - new_target)
                                             : (new_target - active_q);

        if ((SLEW_MAX == 0) || (32'(diff) <= 32'(SLEW_MAX))) begin
            next_active = new_target;
        end else if (active_q > new_target) begin
            next_active = active_q - 8'(SLEW_MAX);
        end else begin
            next_active = active_q + 8'(SLEW_MAX);
        end

        // While a command is pending, cmd_ready is low, so a handshake and a
        // pending consume can never happen in the same cycle.
        if (cmd_valid && !pending_valid_q) begin
            pending_d       = cmd_pos;
            pending_valid_d = 1'b1;
        end

        if (apply) begin
            target_d        = new_target;
            pending_valid_d = 1'b0;
            active_d        = next_active;
            width_d         = pulse_width(next_active);
        end

        case (state_q)
            IDLE: begin
                counter_d = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d   = IDLE;
                    counter_d = '0;
                end else if (counter_q == LAST_COUNT) begin
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                counter_d = '0;
            end
        endcase

        if (state_d == RUN) begin
            frame_start_d = (counter_d == '0);
            pwm_out_d     = (counter_d < width_d);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            counter_q       <= '0;
            width_q         <= pulse_width(CENTER_POS);
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            target_q        <= CENTER_POS;
            active_q        <= CENTER_POS;
            pwm_out_q       <= 1'b0;
            frame_start_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            counter_q       <= counter_d;
            width_q         <= width_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            target_q        <= target_d;
            active_q        <= active_d;
            pwm_out_q       <= pwm_out_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign cmd_ready   = !pending_valid_q;
    assign pwm_out     = pwm_out_q;
    assign frame_start = frame_start_q;
    assign at_target   = (active_q == target_q);

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen
// Directed testbench for servo_pwm_gen. It uses short frames (400 cycles) so
// the run stays small. There are three instances:
//   index 0: STEP_CYCLES=1, no slew limit (the main scenarios)
//   index 1: STEP_CYCLES=2 (checks the width clamp)
//   index 2: STEP_CYCLES=1, SLEW_MAX=8 (checks the per-frame rate limit)
// Width = 20 + position*STEP_CYCLES, clamped to 300.
module tb_servo_pwm_gen;

    logic       clock = 1'b0;
    logic       reset_v     [3];
    logic       enable_v    [3];
    logic       cmd_valid_v [3];
    logic [7:0] cmd_pos_v   [3];
    logic       cmd_ready_v [3];
    logic       pwm_v       [3];
    logic       fs_v        [3];
    logic       at_v        [3];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    servo_pwm_gen #(
        .FRAME_CYCLES(400), .MIN_PULSE(20), .MAX_PULSE(300),
        .STEP_CYCLES(1), .SLEW_MAX(0), .CENTER(128)
    ) dut_base (
        .clock(clock), .reset(reset_v[0]), .enable(enable_v[0]),
        .cmd_valid(cmd_valid_v[0]), .cmd_pos(cmd_pos_v[0]),
        .cmd_ready(cmd_ready_v[0]), .pwm_out(pwm_v[0]),
        .frame_start(fs_v[0]), .at_target(at_v[0])
    );

    servo_pwm_gen #(
        .FRAME_CYCLES(400), .MIN_PULSE(20), .MAX_PULSE(300),
        .STEP_CYCLES(2), .SLEW_MAX(0), .CENTER(128)
    ) dut_step2 (
        .clock(clock), .reset(reset_v[1]), .enable(enable_v[1]),
        .cmd_valid(cmd_valid_v[1]), .cmd_pos(cmd_pos_v[1]),
        .cmd_ready(cmd_ready_v[1]), .pwm_out(pwm_v[1]),
        .frame_start(fs_v[1]), .at_target(at_v[1])
    );

    servo_pwm_gen #(
        .FRAME_CYCLES(400), .MIN_PULSE(20), .MAX_PULSE(300),
        .STEP_CYCLES(1), .SLEW_MAX(8), .CENTER(128)
    ) dut_slew (
        .clock(clock), .reset(reset_v[2]), .enable(enable_v[2]),
        .cmd_valid(cmd_valid_v[2]), .cmd_pos(cmd_pos_v[2]),
        .cmd_ready(cmd_ready_v[2]), .pwm_out(pwm_v[2]),
        .frame_start(fs_v[2]), .at_target(at_v[2])
    );

    // Measures one frame. If frame_start is already high at the current
    // negedge, that cycle is the first cycle of the frame. The task returns at
    // the negedge where the next frame_start is seen.
    task automatic measure(input int idx, output int width, output int period);
        int n;
        n = 0;
        width = 0;
        period = 0;
        while (!fs_v[idx] && n < 1000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!fs_v[idx]) begin
            errors++;
            $display("[TB] FAIL frame_start_timeout dut%0d: got no frame_start, required one within 1000 cycles", idx);
            width = -1;
            period = -1;
            return;
        end
        do begin
            if (pwm_v[idx]) width++;
            period++;
            @(negedge clock);
        end while (!fs_v[idx] && period < 1000);
    endtask

    // Holds cmd_valid until the DUT shows ready, then drops it after the
    // accepting edge.
    task automatic send(input int idx, input logic [7:0] pos);
        int n;
        n = 0;
        cmd_valid_v[idx] = 1'b1;
        cmd_pos_v[idx]   = pos;
        while (!cmd_ready_v[idx] && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready_v[idx]) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout dut%0d: got cmd_ready=0, required 1 within 2000 cycles", idx);
        end
        @(negedge clock);
        cmd_valid_v[idx] = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            reset_v[i] = 1'b1;
            enable_v[i] = 1'b0;
            cmd_valid_v[i] = 1'b0;
            cmd_pos_v[i] = 8'd0;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pwm_v[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_pwm dut%0d: got %b required 0", i, pwm_v[i]); end
            checks++;
            if (fs_v[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start dut%0d: got %b required 0", i, fs_v[i]); end
            checks++;
            if (cmd_ready_v[i] !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready dut%0d: got %b required 1", i, cmd_ready_v[i]); end
            checks++;
            if (at_v[i] !== 1'b1) begin errors++; $display("[TB] FAIL reset_at_target dut%0d: got %b required 1", i, at_v[i]); end
        end
    endtask

    task automatic test_frame_timing();
        int w, p;
        reset_v[0] = 1'b0;
        @(negedge clock);
        checks++;
        if (fs_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_frame: got %b required 0", fs_v[0]); end
        enable_v[0] = 1'b1;
        @(negedge clock);
        checks++;
        if (fs_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL first_frame_start: got %b required 1", fs_v[0]); end
        checks++;
        if (pwm_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL first_pwm_high: got %b required 1", pwm_v[0]); end
        for (int f = 0; f < 2; f++) begin
            measure(0, w, p);
            checks++;
            if (w !== 148) begin errors++; $display("[TB] FAIL center_width frame%0d: got %0d required 148", f, w); end
            checks++;
            if (p !== 400) begin errors++; $display("[TB] FAIL frame_period frame%0d: got %0d required 400", f, p); end
        end
        checks++;
        if (cmd_ready_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready: got %b required 1", cmd_ready_v[0]); end
    endtask

    task automatic test_mid_frame_command();
        int w, p;
        fork
            measure(0, w, p);
            begin
                repeat (50) @(negedge clock);
                send(0, 8'd0);
                checks++;
                if (cmd_ready_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL ready_low_after_accept: got %b required 0", cmd_ready_v[0]); end
                repeat (300) @(negedge clock);
                checks++;
                if (cmd_ready_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL ready_low_until_apply: got %b required 0", cmd_ready_v[0]); end
            end
        join
        checks++;
        if (w !== 148) begin errors++; $display("[TB] FAIL current_frame_unchanged: got %0d required 148", w); end
        checks++;
        if (cmd_ready_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_apply: got %b required 1", cmd_ready_v[0]); end
        checks++;
        if (at_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL at_target_after_jump: got %b required 1", at_v[0]); end
        measure(0, w, p);
        checks++;
        if (w !== 20) begin errors++; $display("[TB] FAIL pos0_width: got %0d required 20", w); end
    endtask

    task automatic test_back_to_back();
        int w, p;
        fork
            measure(0, w, p);
            begin
                repeat (50) @(negedge clock);
                send(0, 8'd100);
                cmd_valid_v[0] = 1'b1;
                cmd_pos_v[0]   = 8'd50;
                repeat (100) @(negedge clock);
                checks++;
                if (cmd_ready_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL second_stalled: got %b required 0", cmd_ready_v[0]); end
            end
        join
        checks++;
        if (w !== 20) begin errors++; $display("[TB] FAIL b2b_frame0: got %0d required 20", w); end
        checks++;
        if (cmd_ready_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_at_apply: got %b required 1", cmd_ready_v[0]); end
        fork
            measure(0, w, p);
            begin
                @(negedge clock);
                cmd_valid_v[0] = 1'b0;
                checks++;
                if (cmd_ready_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL second_accepted: got %b required 0", cmd_ready_v[0]); end
            end
        join
        checks++;
        if (w !== 120) begin errors++; $display("[TB] FAIL b2b_width_100: got %0d required 120", w); end
        measure(0, w, p);
        checks++;
        if (w !== 70) begin errors++; $display("[TB] FAIL b2b_width_50: got %0d required 70", w); end
    endtask

    task automatic test_clamp();
        int w, p;
        reset_v[1] = 1'b0;
        enable_v[1] = 1'b1;
        @(negedge clock);
        fork
            measure(1, w, p);
            begin
                repeat (50) @(negedge clock);
                send(1, 8'd255);
            end
        join
        checks++;
        if (w !== 276) begin errors++; $display("[TB] FAIL step2_center_width: got %0d required 276", w); end
        measure(1, w, p);
        checks++;
        if (w !== 300) begin errors++; $display("[TB] FAIL clamp_width: got %0d required 300", w); end
        checks++;
        if (p !== 400) begin errors++; $display("[TB] FAIL clamp_period: got %0d required 400", p); end
        checks++;
        if (at_v[1] !== 1'b1) begin errors++; $display("[TB] FAIL clamp_at_target: got %b required 1", at_v[1]); end
    endtask

    task automatic test_slew();
        int w, p;
        int exp_w [4] = '{156, 164, 172, 176};
        logic exp_at [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        reset_v[2] = 1'b0;
        enable_v[2] = 1'b1;
        @(negedge clock);
        fork
            measure(2, w, p);
            begin
                repeat (50) @(negedge clock);
                send(2, 8'd156);
            end
        join
        checks++;
        if (w !== 148) begin errors++; $display("[TB] FAIL slew_first_frame: got %0d required 148", w); end
        for (int f = 0; f < 4; f++) begin
            checks++;
            if (at_v[2] !== exp_at[f]) begin errors++; $display("[TB] FAIL slew_at_target step%0d: got %b required %b", f, at_v[2], exp_at[f]); end
            measure(2, w, p);
            checks++;
            if (w !== exp_w[f]) begin errors++; $display("[TB] FAIL slew_width step%0d: got %0d required %0d", f, w, exp_w[f]); end
        end
    endtask

    task automatic test_enable_and_reset();
        int w, p;
        int stray;
        repeat (10) @(negedge clock);
        checks++;
        if (pwm_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL pwm_mid_pulse: got %b required 1", pwm_v[0]); end
        enable_v[0] = 1'b0;
        @(negedge clock);
        checks++;
        if (pwm_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL disable_pwm_low: got %b required 0", pwm_v[0]); end
        stray = 0;
        repeat (20) begin
            if (pwm_v[0] || fs_v[0]) stray++;
            @(negedge clock);
        end
        checks++;
        if (stray !== 0) begin errors++; $display("[TB] FAIL idle_outputs_quiet: got %0d active cycles required 0", stray); end
        enable_v[0] = 1'b1;
        @(negedge clock);
        checks++;
        if (fs_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL reenable_frame_start: got %b required 1", fs_v[0]); end
        measure(0, w, p);
        checks++;
        if (w !== 70 || p !== 400) begin errors++; $display("[TB] FAIL reenable_frame: got width %0d period %0d required 70 400", w, p); end
        repeat (30) @(negedge clock);
        send(0, 8'd200);
        reset_v[0] = 1'b1;
        @(negedge clock);
        checks++;
        if (pwm_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pwm: got %b required 0", pwm_v[0]); end
        checks++;
        if (fs_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL midreset_frame_start: got %b required 0", fs_v[0]); end
        checks++;
        if (cmd_ready_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b required 1", cmd_ready_v[0]); end
        checks++;
        if (at_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL midreset_at_target: got %b required 1", at_v[0]); end
        reset_v[0] = 1'b0;
        @(negedge clock);
        checks++;
        if (fs_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_restart: got %b required 1", fs_v[0]); end
        for (int f = 0; f < 2; f++) begin
            measure(0, w, p);
            checks++;
            if (w !== 148) begin errors++; $display("[TB] FAIL post_reset_width frame%0d: got %0d required 148", f, w); end
        end
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_mid_frame_command();
        test_back_to_back();
        test_enable_and_reset();
        test_clamp();
        test_slew();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
